// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM states, coin values, drink codes and money
// width. The seller stage also uses these definitions.
package vend_pkg;

  localparam int MONEY_W = 6;
  localparam logic [MONEY_W-1:0] MONEY_MAX = 6'd63;

  localparam logic [MONEY_W-1:0] COIN_1  = 6'd1;
  localparam logic [MONEY_W-1:0] COIN_5  = 6'd5;
  localparam logic [MONEY_W-1:0] COIN_10 = 6'd10;
  localparam logic [MONEY_W-1:0] COIN_50 = 6'd50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PENDING,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    DRINK_CANCEL = 2'd0,
    DRINK_D30    = 2'd1,
    DRINK_D20    = 2'd2,
    DRINK_D15    = 2'd3
  } drink_t;

  // Maps the 2-bit coin code from the acceptor to its value in units.
  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    coin_value = COIN_1;
      2'd1:    coin_value = COIN_5;
      2'd2:    coin_value = COIN_10;
      default: coin_value = COIN_50;
    endcase
  endfunction

endpackage

// File: rtl/coin_collector_idle_timer.sv
// Saturating up counter that measures idle cycles. Clear takes priority
// over enable. Expire is high while the count sits at LIMIT-1.
module idle_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign expire = (count == LAST);

  // Idle count: the count holds at LAST so it cannot wrap before the owner reacts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/coin_collector.sv
// Vending front end. It accumulates coin credit, latches the drink selection,
// issues one purchase request to the seller, and waits for completion.
// An idle timeout turns abandoned credit into a refund request.
module coin_collector
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid_i,
  input  logic [1:0]         coin_type_i,
  input  logic               select_valid_i,
  input  logic [1:0]         select_type_i,
  input  logic               ready_i,
  input  logic               done_i,
  output logic               enable_o,
  output logic [MONEY_W-1:0] money_o,
  output logic [1:0]         drinktype_o,
  output logic [MONEY_W-1:0] credit_o,
  output logic               coin_reject_o,
  output logic               busy_o
);

  state_t             state, state_next;
  logic [MONEY_W-1:0] credit_next, money_next, coin_val;
  logic [MONEY_W:0]   credit_sum;
  logic [1:0]         sel_type, sel_next, dtype_next;
  logic               enable_next, reject_next, busy_next;
  logic               coin_fits, coin_accept;
  logic               timer_clear, timer_expire;

  // The 7-bit sum keeps the carry so an overflowing coin is caught instead of wrapping.
  assign coin_val    = coin_value(coin_type_i);
  assign credit_sum  = {1'b0, credit_o} + {1'b0, coin_val};
  assign coin_fits   = (credit_sum <= {1'b0, MONEY_MAX});
  assign coin_accept = coin_valid_i && coin_fits &&
                       ((state == ST_IDLE) || (state == ST_COLLECT));

  // The counter is held at zero outside COLLECT, so every entry to COLLECT starts from zero.
  assign timer_clear = (state != ST_COLLECT) || coin_accept;

  idle_timer #(
    .LIMIT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state == ST_COLLECT),
    .expire (timer_expire)
  );

  // Next-state, credit and next registered output values.
  always_comb begin
    state_next  = state;
    credit_next = credit_o;
    sel_next    = sel_type;
    enable_next = 1'b0;
    money_next  = money_o;
    dtype_next  = drinktype_o;
    reject_next = coin_valid_i && !coin_accept;
    case (state)
      ST_IDLE: begin
        if (coin_accept) begin
          credit_next = credit_sum[MONEY_W-1:0];
          state_next  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (coin_accept) begin
          credit_next = credit_sum[MONEY_W-1:0];
        end
        if (select_valid_i) begin
          sel_next   = select_type_i;
          state_next = ST_PENDING;
        end else if (timer_expire && !coin_accept) begin
          sel_next   = DRINK_CANCEL;
          state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (ready_i) begin
          enable_next = 1'b1;
          money_next  = credit_o;
          dtype_next  = sel_type;
          state_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_i) begin
          credit_next = '0;
          money_next  = '0;
          dtype_next  = DRINK_CANCEL;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next == ST_PENDING) || (state_next == ST_ISSUE) ||
                (state_next == ST_WAIT_DONE);
  end

  // State register and registered outputs. Reset drops any transaction in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      credit_o      <= '0;
      enable_o      <= 1'b0;
      money_o       <= '0;
      drinktype_o   <= DRINK_CANCEL;
      coin_reject_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_next;
      credit_o      <= credit_next;
      enable_o      <= enable_next;
      money_o       <= money_next;
      drinktype_o   <= dtype_next;
      coin_reject_o <= reject_next;
      busy_o        <= busy_next;
    end
  end

  // Latched drink type. It is only read after it has been written in COLLECT.
  always_ff @(posedge clk) begin
    sel_type <= sel_next;
  end

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector. It runs directed scenarios and then
// randomized traffic, with every cycle compared against a behavioural model.
module tb_coin_collector;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, select_valid, ready, done;
  logic [1:0] coin_type, select_type, drinktype;
  logic       enable, coin_reject, busy;
  logic [5:0] money, credit;

  int checks = 0;
  int failures = 0;

  // Model state: session phase, credit, idle cycles, chosen drink and expected outputs.
  localparam int P_IDLE = 0, P_COLLECT = 1, P_WAIT_READY = 2, P_ISSUED = 3, P_WAIT_DONE = 4;
  int m_phase, m_credit, m_idle, m_choice;
  int e_enable, e_money, e_dtype, e_reject, e_busy;

  coin_collector #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .coin_valid_i   (coin_valid),
    .coin_type_i    (coin_type),
    .select_valid_i (select_valid),
    .select_type_i  (select_type),
    .ready_i        (ready),
    .done_i         (done),
    .enable_o       (enable),
    .money_o        (money),
    .drinktype_o    (drinktype),
    .credit_o       (credit),
    .coin_reject_o  (coin_reject),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int units(input int code);
    int table_v[4] = '{1, 5, 10, 50};
    return table_v[code];
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_credit = 0; m_idle = 0; m_choice = 0;
    e_enable = 0; e_money = 0; e_dtype = 0; e_reject = 0; e_busy = 0;
  endtask

  // Advance the model by one clock using the inputs that are currently driven.
  task automatic model_step();
    int  v;
    bit  took;
    v = units(coin_type);
    took = 0;
    e_enable = 0;
    if (m_phase == P_IDLE) begin
      if (coin_valid) begin
        m_credit = v; m_idle = 0; m_phase = P_COLLECT; took = 1;
      end
    end else if (m_phase == P_COLLECT) begin
      if (coin_valid && (m_credit + v <= 63)) begin
        m_credit += v; took = 1;
      end
      if (select_valid) begin
        m_choice = select_type; m_phase = P_WAIT_READY;
      end else if (!took && m_idle == TO - 1) begin
        m_choice = 0; m_phase = P_WAIT_READY;
      end else begin
        m_idle = took ? 0 : m_idle + 1;
      end
    end else if (m_phase == P_WAIT_READY) begin
      if (ready) begin
        e_enable = 1; e_money = m_credit; e_dtype = m_choice; m_phase = P_ISSUED;
      end
    end else if (m_phase == P_ISSUED) begin
      m_phase = P_WAIT_DONE;
    end else begin
      if (done) begin
        m_credit = 0; e_money = 0; e_dtype = 0; m_phase = P_IDLE;
      end
    end
    e_reject = (coin_valid && !took) ? 1 : 0;
    e_busy   = (m_phase >= P_WAIT_READY) ? 1 : 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".credit"},    credit,      m_credit);
    chk({tag, ".enable"},    enable,      e_enable);
    chk({tag, ".money"},     money,       e_money);
    chk({tag, ".drinktype"}, drinktype,   e_dtype);
    chk({tag, ".reject"},    coin_reject, e_reject);
    chk({tag, ".busy"},      busy,        e_busy);
  endtask

  // One clock: drive the inputs, update the model, then sample 1 ns after the edge.
  task automatic cyc(input bit cv, input int ct, input bit sv, input int st,
                     input bit rd, input bit dn, input string tag);
    coin_valid = cv; coin_type = 2'(ct);
    select_valid = sv; select_type = 2'(st);
    ready = rd; done = dn;
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_cyc(input string tag);
    cyc(0, 0, 0, 0, 1, 0, tag);
  endtask

  // Reset is asserted between edges; the outputs must clear without waiting for a clock.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    coin_valid = 0; select_valid = 0; done = 0;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    coin_valid = 0; coin_type = 0; select_valid = 0; select_type = 0;
    ready = 0; done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;

    // Coins 10,10,10 followed by select 1, then done.
    cyc(1, 2, 0, 0, 1, 0, "p1.c1");
    cyc(1, 2, 0, 0, 1, 0, "p1.c2");
    cyc(1, 2, 0, 0, 1, 0, "p1.c3");
    chk("p1.credit30", credit, 30);
    cyc(0, 0, 1, 1, 1, 0, "p1.sel");
    cyc(0, 0, 0, 0, 1, 0, "p1.issue");
    chk("p1.en", enable, 1);
    chk("p1.money30", money, 30);
    idle_cyc("p1.wait");
    cyc(0, 0, 0, 0, 1, 1, "p1.done");
    chk("p1.credit0", credit, 0);

    // Coins 50 and 10, then a refused 5, then an accepted 1.
    cyc(1, 3, 0, 0, 1, 0, "p2.c50");
    cyc(1, 2, 0, 0, 1, 0, "p2.c10");
    cyc(1, 1, 0, 0, 1, 0, "p2.c5rej");
    chk("p2.reject", coin_reject, 1);
    chk("p2.credit60", credit, 60);
    cyc(1, 0, 0, 0, 1, 0, "p2.c1");
    chk("p2.credit61", credit, 61);
    cyc(0, 0, 1, 0, 1, 0, "p2.cancel");
    idle_cyc("p2.issue");
    idle_cyc("p2.wait");
    cyc(0, 0, 0, 0, 1, 1, "p2.done");

    // Coin 5 together with select 3 in the same COLLECT cycle.
    cyc(1, 0, 0, 0, 1, 0, "p3.c1");
    cyc(1, 1, 1, 3, 1, 0, "p3.c5sel");
    idle_cyc("p3.issue");
    chk("p3.money6", money, 6);
    chk("p3.dtype3", drinktype, 3);
    idle_cyc("p3.wait");
    cyc(0, 0, 0, 0, 1, 1, "p3.done");

    // Coin 10 then silence: the refund request follows after the timeout.
    cyc(1, 2, 0, 0, 1, 0, "p4.c10");
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      idle_cyc("p4.idle");
      if (enable && lat < 0) begin
        lat = i;
        chk("p4.money10", money, 10);
        chk("p4.dtype0", drinktype, 0);
      end
    end
    chk("p4.latency", lat, TO + 1);
    cyc(0, 0, 0, 0, 1, 1, "p4.done");

    // ready held low after select: the block holds, and coins are refused.
    cyc(1, 2, 0, 0, 0, 0, "p5.c10");
    cyc(0, 0, 1, 2, 0, 0, "p5.sel");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 1, "p5.hold");
      chk("p5.busy", busy, 1);
    end
    cyc(0, 0, 0, 0, 1, 0, "p5.ready");
    chk("p5.en", enable, 1);
    idle_cyc("p5.after");

    // Reset arrives while waiting for done; a later coin starts a fresh credit.
    mid_reset("p6.reset");
    cyc(1, 0, 0, 0, 1, 0, "p6.c1");
    chk("p6.credit1", credit, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset("rnd.reset");
      end else begin
        cyc($urandom_range(0, 9) < 3, $urandom_range(0, 3),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3),
            $urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
